yarp_mem_arbiter: RTL

Shares one single-port memory between the core's instruction-fetch port and its load/store data port. It accepts one request at a time from either side and holds the memory request until the memory accepts it. It then routes the single response back to the side that issued it. Sits between the instruction-memory interface, the data-memory interface and the shared memory macro/bus.

---
 rtl/yarp_mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter: shares one single-port memory between the instruction
// fetch port and the load/store data port. There is only ever one
// transaction in flight. It moves ARB -> REQ -> RSP, and the single
// response is routed back to whichever side was granted.
//
// Handshake rules for all three ports:
//   A requester holds req and its payload until it sees gnt for one cycle.
//   mem_req_o is held with a stable payload until mem_gnt_i is high.
//   Each granted transaction produces exactly one rvalid pulse, and that
//   pulse goes to the owner only.
module yarp_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                imem_req_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic                imem_gnt_o,
  output logic                imem_rvalid_o,
  output logic [DATA_W-1:0]   imem_rdata_o,
  input  logic                dmem_req_i,
  input  logic                dmem_we_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  input  logic [DATA_W/8-1:0] dmem_be_i,
  output logic                dmem_gnt_o,
  output logic                dmem_rvalid_o,
  output logic [DATA_W-1:0]   dmem_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                spurious_rsp_o,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_ARB = 2'd0,
    ST_REQ = 2'd1,
    ST_RSP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  owner_t           owner_q;
  logic [CNT_W-1:0] starve_q;
  logic             fetch_forced;

  assign dbg_state    = state_q;
  assign fetch_forced = imem_req_i && (starve_q == STARVE_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  // Next-state logic: a grant leaves ARB, mem_gnt_i leaves REQ, and the response leaves RSP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB:  if (imem_gnt_o || dmem_gnt_o) state_d = ST_REQ;
      ST_REQ:  if (mem_gnt_i)                state_d = ST_RSP;
      ST_RSP:  if (mem_rvalid_i)             state_d = ST_ARB;
      default:                               state_d = ST_ARB;
    endcase
  end

  // Output decode: grants from live requests in ARB, response steering in RSP, spurious flag elsewhere
  always_comb begin
    imem_gnt_o     = 1'b0;
    dmem_gnt_o     = 1'b0;
    imem_rvalid_o  = 1'b0;
    dmem_rvalid_o  = 1'b0;
    imem_rdata_o   = '0;
    dmem_rdata_o   = '0;
    mem_req_o      = 1'b0;
    spurious_rsp_o = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_ARB: begin
          // Data normally wins; a fetch starved STARVE_LIMIT times goes first
          dmem_gnt_o     = dmem_req_i && !fetch_forced;
          imem_gnt_o     = imem_req_i && (fetch_forced || !dmem_req_i);
          spurious_rsp_o = mem_rvalid_i;
        end
        ST_REQ: begin
          mem_req_o      = 1'b1;
          spurious_rsp_o = mem_rvalid_i;
        end
        ST_RSP: begin
          imem_rvalid_o = mem_rvalid_i && (owner_q == OWN_IMEM);
          dmem_rvalid_o = mem_rvalid_i && (owner_q == OWN_DMEM);
          imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
          dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;
        end
        default: ;
      endcase
    end
  end

  // Request payload, owner and starvation counter, all captured on a grant
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else if (dmem_gnt_o) begin
      owner_q     <= OWN_DMEM;
      mem_we_o    <= dmem_we_i;
      mem_addr_o  <= dmem_addr_i;
      mem_wdata_o <= dmem_wdata_i;
      mem_be_o    <= dmem_be_i;
      // Only count wins that actually made a fetch wait
      if (!imem_req_i)              starve_q <= '0;
      else if (starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
    end else if (imem_gnt_o) begin
      owner_q     <= OWN_IMEM;
      starve_q    <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= imem_addr_i;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end
  end

endmodule
